// File: rtl/mem_wb_skid_pipe.sv
// MEM->WB pipeline stage: valid/ready handshake with a 2-entry skid buffer,
// a synchronous flush and a saturating stall-cycle counter.
module mem_wb_skid_pipe #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]         stall_cnt,
    input  logic                     clr_cnt
);

    localparam int BUS_W = NUM_CH * DATA_W;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_TWO   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [BUS_W-1:0] main_data_q, main_data_d;
    logic [BUS_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] state;
    logic       in_fire;
    logic       out_fire;
    logic       stalled;

    // in_ready depends only on the skid flag, so out_ready never reaches it combinationally.
    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign stall_cnt = cnt_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_v_q & out_ready;
    assign stalled  = main_v_q & ~out_ready;
    assign state    = {main_v_q, skid_v_q};

    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Held bundles are dropped; data registers keep their contents.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_v_d    = 1'b1;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        skid_v_d    = 1'b1;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        main_v_d = 1'b0;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        skid_v_d    = 1'b0;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    // Skid-only is unreachable; fall back to empty.
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (stalled && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_data_q <= '0;
            skid_data_q <= '0;
            cnt_q       <= '0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_skid_pipe.sv
// Bench for mem_wb_skid_pipe: directed scenarios plus random traffic, checked
// by a negedge monitor against a queue-based model of the held bundles.
module tb_mem_wb_skid_pipe;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 4;
    localparam int W      = DATA_W * NUM_CH;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] stall_cnt;
    logic             clr_cnt = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Model: queue of bundles held by the stage, oldest first (capacity 2).
    logic [W-1:0] sb[$];
    int           mcnt = 0;

    mem_wb_skid_pipe #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .clr_cnt   (clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare DUT against the model, then advance the model across the next edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_out_data", 64'(out_data), 64'd0);
            chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
            sb.delete();
            mcnt = 0;
        end else begin
            automatic bit acc   = in_valid && (sb.size() < 2);
            automatic bit stall = (sb.size() > 0) && !out_ready;
            chk("out_valid", 64'(out_valid), 64'(sb.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
            chk("stall_cnt", 64'(stall_cnt), 64'(mcnt));
            if (sb.size() > 0) begin
                chk("out_data", 64'(out_data), 64'(sb[0]));
                if (out_ready) void'(sb.pop_front());
            end
            if (flush) sb.delete();
            else if (acc) sb.push_back(in_data);
            if (clr_cnt) mcnt = 0;
            else if (stall && mcnt < CMAX) mcnt++;
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r,
                         input logic f, input logic c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        clr_cnt   = c;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rep(input logic [DATA_W-1:0] x);
        return {NUM_CH{x}};
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming with WB always ready.
        drive(1, rep(16'h0011), 1, 0, 0);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        drive(1, rep(16'h0022), 1, 0, 0);
        drive(1, rep(16'h0033), 1, 0, 0);
        chk("t1_out_data", 64'(out_data), 64'(rep(16'h0033)));
        drive(0, '0, 1, 0, 0);
        chk("t1_stall_cnt", 64'(stall_cnt), 64'd0);

        // Stall fills the skid entry, then drains in order.
        drive(0, '0, 1, 0, 1);
        drive(1, rep(16'h000A), 0, 0, 0);
        drive(1, rep(16'h000B), 0, 0, 0);
        chk("t2_in_ready_full", 64'(in_ready), 64'd0);
        drive(0, '0, 0, 0, 0);
        drive(0, '0, 1, 0, 0);
        chk("t2_out_b", 64'(out_data), 64'(rep(16'h000B)));
        drive(0, '0, 1, 0, 0);
        chk("t2_in_ready_back", 64'(in_ready), 64'd1);
        chk("t2_stall_cnt", 64'(stall_cnt), 64'd2);

        // Flush while full, with a competing input that must be discarded.
        drive(1, rep(16'h0C01), 0, 0, 1);
        drive(1, rep(16'h0C02), 0, 0, 0);
        drive(1, rep(16'h000C), 0, 1, 0);
        chk("t3_out_valid", 64'(out_valid), 64'd0);
        chk("t3_in_ready", 64'(in_ready), 64'd1);
        chk("t3_data_kept", 64'(out_data), 64'(rep(16'h0C01)));
        drive(0, '0, 1, 0, 0);
        chk("t3_no_c", 64'(out_valid), 64'd0);

        // Counter saturation and clear during a stall.
        drive(0, '0, 1, 0, 1);
        drive(1, rep(16'h0D0D), 0, 0, 0);
        repeat (20) drive(0, '0, 0, 0, 0);
        chk("t4_saturated", 64'(stall_cnt), 64'(CMAX));
        drive(0, '0, 0, 0, 1);
        chk("t4_cleared", 64'(stall_cnt), 64'd0);
        drive(0, '0, 1, 0, 0);

        // Asynchronous reset in the middle of a cycle while full.
        drive(1, rep(16'h0E01), 0, 0, 0);
        drive(1, rep(16'h0E02), 0, 0, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        chk("t5_out_data", 64'(out_data), 64'd0);
        chk("t5_stall_cnt", 64'(stall_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic on both sides with occasional flush and counter clear.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 3) != 0, W'({$urandom(), $urandom()}),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0,
                  $urandom_range(0, 199) == 0);
        end
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 0, 0);
        chk("t6_drained", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
